mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipelined CPU's instruction fetch (IF) and data access (MEM stage).
- Sits between the CPU core's addrInst/instIn and addrData/dataIn/memRE/memWE/dataOut pins and a unified memory that answers with an ack.
- Serialises the two requesters with a small FSM and generates per-stage stall signals for the core's stall/forwarding logic.
- Detects memory non-response with a watchdog.

Parameters:
ACK_TIMEOUT, 255, max cycles in a wait state before abort; 8-bit counter, legal range 1..255
PC_RESET, 32'h0000_0000, value of held fetch address (buffer tag) after reset

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  32  fetch address, word aligned
if_inst  out  32  fetched instruction, valid when if_ready
if_ready  out  1  one-cycle fetch-complete pulse
d_re  in  1  data read request; held until d_ready
d_we  in  1  data write request; held until d_ready; d_re&d_we is illegal
d_addr  in  32  data address
d_wdata  in  32  write data
d_rdata  out  32  read data, valid when d_ready
d_ready  out  1  one-cycle data-complete pulse
if_stall  out  1  if_req & ~if_ready (combinational)
mem_stall  out  1  (d_re|d_we) & ~d_ready (combinational)
mem_addr  out  32  memory address (registered)
mem_re  out  1  memory read strobe (registered)
mem_we  out  1  memory write strobe (registered)
mem_wdata  out  32  memory write data (registered)
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; mem_re=mem_we=0; mem_addr=mem_wdata=0; if_ready=d_ready=0; if_inst=d_rdata=0; timeout_err=0; last_grant=IF; watchdog=0.
- States: IDLE, WAIT_IF, WAIT_D, RESP.
- IDLE arbitration on sampled requests:
  - data only -> WAIT_D; fetch only -> WAIT_IF.
  - Both pending: data wins unless last_grant==D, then fetch wins. Neither requester starves.
  - Entering a wait state registers mem_addr/mem_re/mem_we/mem_wdata on the same edge and updates last_grant.
- WAIT_x: strobes held constant. Watchdog increments each cycle.
  - On mem_ack: capture mem_rdata into if_inst (WAIT_IF) or d_rdata (WAIT_D, reads only). Drop strobes. Pulse matching ready next cycle. Go to RESP.
- RESP: one cycle; ready high; no new request sampled; -> IDLE.
- Minimum latency: request seen in IDLE cycle N, mem strobe N+1, ack N+1 -> ready N+2. Back-to-back transaction starts at N+3.
- Watchdog: reaching ACK_TIMEOUT in a wait state drops strobes, sets timeout_err, and goes to RESP with ready pulsed and data=32'hDEAD_BEEF so the pipeline does not hang. Cleared only by rst.
- mem_ack in IDLE or RESP (late/spurious) is ignored.
- Write completion: d_ready pulses; d_rdata unchanged.
- Requests are not re-sampled while in WAIT_x; changes to inputs mid-transaction have no effect.
- rst mid-transaction: next edge returns to reset values. The outstanding ack is ignored.
- d_re&d_we both high: treat as write. Simulation-only assertion flags it.

Optional Feature:
MEM_PORT_ARBITER_IBUF_EN
- Defined: one-entry fetch buffer (valid, tag, data).
  - In IDLE, fetch with if_addr==tag and valid, and no data request, skips memory: RESP next cycle with buffered if_inst (latency 1).
  - Buffer fills on every completed non-timeout fetch.
  - Invalidated by rst, timeout, or any data write whose d_addr==tag.
- Undefined: every fetch goes to memory; no buffer state.

Decomposition:
- Shared package mem_arb_pkg: state encoding (2-bit IDLE/WAIT_IF/WAIT_D/RESP), grant encoding, TIMEOUT_DATA constant 32'hDEAD_BEEF.
- One natural sub-module: mem_arb_watchdog (8-bit counter with clear/enable, terminal-count output).

Test Plan:
- Fetch only, if_addr=0x40, ack 3 cycles after strobe, mem_rdata=0x2010_0005 -> if_inst=0x2010_0005, if_ready pulse 1 cycle, if_stall high until then.
- Simultaneous fetch 0x44 and read 0x100, last_grant=IF -> data granted first, then fetch. Repeat with last_grant=D -> fetch first.
- Write 0x200 data 0xA5A5_A5A5 -> mem_we=1 with those values until ack; d_ready pulse; d_rdata unchanged.
- No ack with ACK_TIMEOUT=4 -> strobes drop after 4 wait cycles; timeout_err=1; ready pulse with 0xDEAD_BEEF; timeout_err stays 1 until rst.
- rst asserted in WAIT_D, ack arrives the cycle after -> outputs at reset values; no ready pulse.
- IBUF_EN: fetch 0x80 twice -> second completes in 1 cycle with no mem_re. Write to 0x80, then fetch -> goes to memory.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state/grant encodings and constants for mem_port_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } arb_grant_t;

    // Returned to the requester when the memory never answers.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - saturating 8-bit wait-cycle counter with terminal-count flag
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr_i      force count to zero (has priority over en_i)
//   en_i       count one cycle
//   tc_o       high during the LIMIT-th counted cycle
module mem_arb_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // The count is zero in the first wait cycle, so the LIMIT-th wait
    // cycle is the one where the count equals LIMIT-1.
    assign tc_o = (cnt_q == 8'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates CPU fetch and data ports onto one ack-based memory port
//
// Optional feature macro: MEM_PORT_ARBITER_IBUF_EN (one-entry fetch buffer).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr -> if_inst/if_ready   fetch requester (request held until ready)
//   d_re/d_we/d_addr/d_wdata -> d_rdata/d_ready   data requester
//   if_stall, mem_stall               per-stage stalls for the core
//   mem_addr/mem_re/mem_we/mem_wdata  registered memory request
//   mem_rdata/mem_ack                 memory response
//   timeout_err                       sticky no-response flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_ready,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        if_stall,
    output logic        mem_stall,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    arb_state_t  state_q;
    arb_grant_t  last_grant_q;
    logic [31:0] mem_addr_q, mem_wdata_q, if_inst_q, d_rdata_q;
    logic        mem_re_q, mem_we_q, if_ready_q, d_ready_q, timeout_err_q;

    logic data_req, in_wait, grant_d, wd_tc, timeout_hit;
    logic ibuf_valid, ibuf_hit;
    logic [31:0] ibuf_tag, ibuf_data;

    assign data_req    = d_re | d_we;
    assign in_wait     = (state_q == WAIT_IF) || (state_q == WAIT_D);
    // Data wins a tie unless it also won the previous grant.
    assign grant_d     = (state_q == IDLE) && data_req &&
                         (!if_req || (last_grant_q != GRANT_D));
    // A same-cycle ack beats the watchdog.
    assign timeout_hit = in_wait && wd_tc && !mem_ack;
    assign ibuf_hit    = ibuf_valid && (if_addr == ibuf_tag);

    mem_arb_watchdog #(
        .LIMIT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_wait),
        .en_i  (in_wait),
        .tc_o  (wd_tc)
    );

`ifdef MEM_PORT_ARBITER_IBUF_EN
    logic        ibuf_valid_q;
    logic [31:0] ibuf_tag_q, ibuf_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_valid_q <= 1'b0;
            ibuf_tag_q   <= PC_RESET;
            ibuf_data_q  <= '0;
        end else if ((state_q == WAIT_IF) && mem_ack) begin
            ibuf_valid_q <= 1'b1;
            ibuf_tag_q   <= mem_addr_q;
            ibuf_data_q  <= mem_rdata;
        end else if (timeout_hit) begin
            ibuf_valid_q <= 1'b0;
        end else if (grant_d && d_we && (d_addr == ibuf_tag_q)) begin
            ibuf_valid_q <= 1'b0;
        end
    end

    assign ibuf_valid = ibuf_valid_q;
    assign ibuf_tag   = ibuf_tag_q;
    assign ibuf_data  = ibuf_data_q;
`else
    assign ibuf_valid = 1'b0;
    assign ibuf_tag   = PC_RESET;
    assign ibuf_data  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_IF;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            if_inst_q     <= '0;
            d_rdata_q     <= '0;
            if_ready_q    <= 1'b0;
            d_ready_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q      <= WAIT_D;
                        last_grant_q <= GRANT_D;
                        mem_addr_q   <= d_addr;
                        mem_wdata_q  <= d_wdata;
                        // Read and write together is treated as a write.
                        mem_we_q     <= d_we;
                        mem_re_q     <= !d_we;
                    end else if (if_req && !data_req && ibuf_hit) begin
                        state_q      <= RESP;
                        last_grant_q <= GRANT_IF;
                        if_inst_q    <= ibuf_data;
                        if_ready_q   <= 1'b1;
                    end else if (if_req) begin
                        state_q      <= WAIT_IF;
                        last_grant_q <= GRANT_IF;
                        mem_addr_q   <= if_addr;
                        mem_re_q     <= 1'b1;
                        mem_we_q     <= 1'b0;
                    end
                end
                WAIT_IF, WAIT_D: begin
                    if (mem_ack || timeout_hit) begin
                        state_q  <= RESP;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (state_q == WAIT_IF) begin
                            if_ready_q <= 1'b1;
                            if_inst_q  <= mem_ack ? mem_rdata : TIMEOUT_DATA;
                        end else begin
                            d_ready_q <= 1'b1;
                            if (!mem_ack) begin
                                d_rdata_q <= TIMEOUT_DATA;
                            end else if (mem_re_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end
                        if (!mem_ack) begin
                            timeout_err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_inst     = if_inst_q;
    assign if_ready    = if_ready_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign timeout_err = timeout_err_q;
    assign if_stall    = if_req & ~if_ready_q;
    assign mem_stall   = data_req & ~d_ready_q;

`ifndef SYNTHESIS
    a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(d_re && d_we))
        else $error("mem_port_arbiter: illegal simultaneous d_re and d_we");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int          TO   = 4;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, d_re, d_we, d_ready, if_stall, mem_stall;
    logic        mem_re, mem_we, mem_ack, timeout_err;
    logic [31:0] if_addr, if_inst, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ACK_TIMEOUT (TO),
        .PC_RESET    (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_inst     (if_inst),
        .if_ready    (if_ready),
        .d_re        (d_re),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .if_stall    (if_stall),
        .mem_stall   (mem_stall),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit [31:0]   mem_model [bit [31:0]];
    bit          last_d;
    logic [31:0] exp_if_inst, exp_d_rdata;
    bit          exp_terr;
`ifdef MEM_PORT_ARBITER_IBUF_EN
    bit          ib_valid;
    logic [31:0] ib_tag, ib_data;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    task automatic model_reset();
        last_d      = 1'b0;
        exp_if_inst = '0;
        exp_d_rdata = '0;
        exp_terr    = 1'b0;
`ifdef MEM_PORT_ARBITER_IBUF_EN
        ib_valid = 1'b0;
        ib_tag   = '0;
`endif
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_mem_addr"},  mem_addr, 32'h0);
        check_eq({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
        check_eq({pfx, "_strobes"},   32'({mem_re, mem_we}), 32'h0);
        check_eq({pfx, "_if_inst"},   if_inst, 32'h0);
        check_eq({pfx, "_d_rdata"},   d_rdata, 32'h0);
        check_eq({pfx, "_readies"},   32'({if_ready, d_ready}), 32'h0);
        check_eq({pfx, "_timeout"},   32'(timeout_err), 32'h0);
    endtask

    // One arbitration episode: the requested port(s) are raised together and
    // held until their ready pulse. The bench also plays the memory.
    task automatic run_txn(input bit do_if, input logic [31:0] ia,
                           input bit do_d, input bit dw, input logic [31:0] da,
                           input logic [31:0] dwd, input int fix_lat, input bit no_ack);
        bit if_pend, d_pend, busy, cur_d, rdy_if, rdy_d, want_d;
        int lat, scyc, next_strobe;
        if_pend = do_if; d_pend = do_d; busy = 0; cur_d = 0; rdy_if = 0; rdy_d = 0;
        want_d = 0; lat = 0; scyc = 0; next_strobe = 1;
        @(negedge clk);
        if_req = do_if; if_addr = ia; d_re = do_d & ~dw; d_we = do_d & dw;
        d_addr = da; d_wdata = dwd;
        #1;
        check_eq("if_stall_start", 32'(if_stall), 32'(do_if));
        check_eq("mem_stall_start", 32'(mem_stall), 32'(do_d));
        for (int k = 1; k <= 60 && (if_pend || d_pend); k++) begin
            @(negedge clk);
`ifdef MEM_PORT_ARBITER_IBUF_EN
            if (!busy && !rdy_if && !rdy_d && k == next_strobe && if_pend && !d_pend &&
                ib_valid && ib_tag == ia) begin
                rdy_if = 1; exp_if_inst = ib_data; last_d = 0;
            end
`endif
            if (rdy_if || rdy_d) begin
                check_eq("if_ready", 32'(if_ready), 32'(rdy_if));
                check_eq("d_ready", 32'(d_ready), 32'(rdy_d));
                check_eq("strobe_drop", 32'({mem_re, mem_we}), 32'h0);
                if (rdy_if) begin
                    check_eq("if_inst", if_inst, exp_if_inst);
                    check_eq("if_stall_done", 32'(if_stall), 32'h0);
                    if_req = 0; if_pend = 0;
                end
                if (rdy_d) begin
                    check_eq("d_rdata", d_rdata, exp_d_rdata);
                    check_eq("mem_stall_done", 32'(mem_stall), 32'h0);
                    d_re = 0; d_we = 0; d_pend = 0;
                end
                check_eq("timeout_err", 32'(timeout_err), 32'(exp_terr));
                rdy_if = 0; rdy_d = 0; busy = 0; mem_ack = 0;
                next_strobe = k + 2;
            end else begin
                check_eq("no_ready", 32'({if_ready, d_ready}), 32'h0);
                if (!busy && k < next_strobe) begin
                    check_eq("early_strobe", 32'({mem_re, mem_we}), 32'h0);
                end else if (!busy && k == next_strobe) begin
                    want_d = d_pend && (!if_pend || !last_d);
                    check_eq("grant_strobe", 32'(mem_re | mem_we), 32'h1);
                    if (mem_re | mem_we) begin
                        if (want_d) begin
                            check_eq("d_mem_addr", mem_addr, da);
                            check_eq("d_strobe", 32'({mem_re, mem_we}), 32'({~dw, dw}));
                            if (dw) check_eq("d_mem_wdata", mem_wdata, dwd);
`ifdef MEM_PORT_ARBITER_IBUF_EN
                            if (dw && da == ib_tag) ib_valid = 0;
`endif
                        end else begin
                            check_eq("if_mem_addr", mem_addr, ia);
                            check_eq("if_strobe", 32'({mem_re, mem_we}), 32'h2);
                        end
                        check_eq("if_stall_wait", 32'(if_stall), 32'(if_pend));
                        check_eq("mem_stall_wait", 32'(mem_stall), 32'(d_pend));
                        last_d = want_d; cur_d = want_d; busy = 1; scyc = 0;
                        lat = no_ack ? 1000 : (fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 2)));
                    end
                end
                if (busy) begin
                    scyc++;
                    check_eq("strobe_held", 32'({mem_re, mem_we}),
                             cur_d ? 32'({~dw, dw}) : 32'h2);
                    if (lat == 0) begin
                        mem_ack = 1;
                        if (cur_d && dw) begin
                            mem_model[da] = dwd; mem_rdata = $urandom; rdy_d = 1;
                        end else if (cur_d) begin
                            exp_d_rdata = mem_rd(da); mem_rdata = exp_d_rdata; rdy_d = 1;
                        end else begin
                            exp_if_inst = mem_rd(ia); mem_rdata = exp_if_inst; rdy_if = 1;
`ifdef MEM_PORT_ARBITER_IBUF_EN
                            ib_valid = 1; ib_tag = ia; ib_data = exp_if_inst;
`endif
                        end
                    end else begin
                        lat--; mem_ack = 0; mem_rdata = $urandom;
                        if (scyc == TO) begin
                            exp_terr = 1;
`ifdef MEM_PORT_ARBITER_IBUF_EN
                            ib_valid = 0;
`endif
                            if (cur_d) begin exp_d_rdata = DEAD; rdy_d = 1; end
                            else begin exp_if_inst = DEAD; rdy_if = 1; end
                        end
                    end
                end
            end
        end
        check_eq("txn_done", 32'({if_pend, d_pend}), 32'h0);
        mem_ack = 0; if_req = 0; d_re = 0; d_we = 0;
    endtask

    // Quiet cycles with spurious acks that must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'({if_ready, d_ready}), 32'h0);
            check_eq("idle_strobe", 32'({mem_re, mem_we}), 32'h0);
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 0;
        check_eq("idle_if_inst", if_inst, exp_if_inst);
        check_eq("idle_d_rdata", d_rdata, exp_d_rdata);
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = '0; d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check_reset_vals("reset");
        check_eq("reset_if_stall", 32'(if_stall), 32'h0);

        // Fetch with ack on the 4th strobe cycle (same cycle as watchdog terminal count)
        mem_model[32'h40] = 32'h2010_0005;
        run_txn(1, 32'h40, 0, 0, 0, 0, 3, 0);
        check_eq("fetch_0x40", if_inst, 32'h2010_0005);

        // Tie with last grant IF: data first, then fetch
        run_txn(1, 32'h44, 1, 0, 32'h100, 0, 0, 0);
        // Data alone, then tie with last grant D: fetch first
        run_txn(0, 0, 1, 0, 32'h104, 0, 1, 0);
        run_txn(1, 32'h48, 1, 0, 32'h108, 0, 0, 0);

        // Write, then read it back
        run_txn(0, 0, 1, 1, 32'h200, 32'hA5A5_A5A5, 2, 0);
        run_txn(0, 0, 1, 0, 32'h200, 0, 0, 0);
        check_eq("readback_0x200", d_rdata, 32'hA5A5_A5A5);

`ifdef MEM_PORT_ARBITER_IBUF_EN
        run_txn(1, 32'h80, 0, 0, 0, 0, 1, 0);
        run_txn(1, 32'h80, 0, 0, 0, 0, 1, 0);
        run_txn(0, 0, 1, 1, 32'h80, 32'h1357_9BDF, 0, 0);
        run_txn(1, 32'h80, 0, 0, 0, 0, 1, 0);
        check_eq("ibuf_refetch", if_inst, 32'h1357_9BDF);
`endif

        idle_cycles(3);

        for (int t = 0; t < 30; t++) begin
            bit fi, fd, fw;
            fi = 1'($urandom_range(0, 1));
            fd = 1'($urandom_range(0, 1));
            fw = 1'($urandom_range(0, 1));
            if (!fi && !fd) fd = 1;
            run_txn(fi, 32'h80 + 4 * $urandom_range(0, 7), fd, fw,
                    32'h80 + 4 * $urandom_range(0, 7), $urandom, -1, 0);
        end

        // Memory never answers: watchdog completes the read with the marker
        run_txn(0, 0, 1, 0, 32'h300, 0, -1, 1);
        check_eq("timeout_data", d_rdata, DEAD);
        run_txn(1, 32'h4C, 0, 0, 0, 0, 0, 0);
        idle_cycles(4);
        check_eq("timeout_sticky", 32'(timeout_err), 32'h1);

        // Reset while waiting on a data read; the late ack must be ignored
        @(negedge clk);
        d_re = 1; d_addr = 32'h104;
        @(negedge clk);
        check_eq("rst_wait_strobe", 32'(mem_re), 32'h1);
        rst = 1;
        @(negedge clk);
        rst = 0; d_re = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
        model_reset();
        check_reset_vals("rst_mid");
        @(negedge clk);
        mem_ack = 0;
        check_reset_vals("rst_after_ack");

        // last_grant back to IF: a tie grants data first again
        run_txn(1, 32'h50, 1, 0, 32'h10C, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
